// File: rtl/button_decoder.sv
// Debounced push-button decoder: synchronizes sw_n and emits press, short-press and long-press pulses.
// Define BUTTON_DECODER_LONG_PRESS_EN to build the hold counter and long_press output.
module button_decoder #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_n,
    output logic pressed,
    output logic press_pulse,
    output logic short_press,
    output logic long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] cnt_reg, cnt_next;
    logic [1:0]    sync_reg;
    logic          sw_s;
    logic          pressed_reg, pressed_next;
    logic          press_pulse_reg, press_pulse_next;
    logic          short_press_reg, short_press_next;
    logic          rel_done;
    logic          suppress_short;

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], sw_n};
        end
    end

    assign sw_s = sync_reg[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            pressed_reg     <= 1'b0;
            press_pulse_reg <= 1'b0;
            short_press_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            pressed_reg     <= pressed_next;
            press_pulse_reg <= press_pulse_next;
            short_press_reg <= short_press_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        pressed_next     = pressed_reg;
        press_pulse_next = 1'b0;
        rel_done         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!sw_s) begin
                    state_next = DEB_PRESS;
                    cnt_next   = '0;
                end
            end
            DEB_PRESS: begin
                if (sw_s) begin
                    state_next = IDLE;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next       = HELD;
                    pressed_next     = 1'b1;
                    press_pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (sw_s) begin
                    state_next = DEB_REL;
                    cnt_next   = '0;
                end
            end
            DEB_REL: begin
                if (!sw_s) begin
                    state_next = HELD;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next   = IDLE;
                    pressed_next = 1'b0;
                    rel_done     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign short_press_next = rel_done && !suppress_short;

`ifdef BUTTON_DECODER_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_reg;
    logic          long_flag_reg;
    logic          long_press_reg;
    logic          long_fire;

    // A release completing on the same edge wins: long_press is only for a button still held.
    assign long_fire = pressed_reg && !long_flag_reg && (hold_reg == HOLD_LAST) && !rel_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg       <= '0;
            long_flag_reg  <= 1'b0;
            long_press_reg <= 1'b0;
        end else begin
            if (press_pulse_next) begin
                hold_reg <= '0;
            end else if (pressed_reg && (hold_reg != HOLD_MAX)) begin
                hold_reg <= hold_reg + 1'b1;
            end
            if (state_next == IDLE) begin
                long_flag_reg <= 1'b0;
            end else if (long_fire) begin
                long_flag_reg <= 1'b1;
            end
            long_press_reg <= long_fire;
        end
    end

    assign suppress_short = long_flag_reg;
    assign long_press     = long_press_reg;
`else
    assign suppress_short = 1'b0;
    // LONG_CYCLES has no effect in this build; the term folds to a constant 0.
    assign long_press     = 1'b0 & (LONG_CYCLES != 0);
`endif

    assign pressed     = pressed_reg;
    assign press_pulse = press_pulse_reg;
    assign short_press = short_press_reg;

endmodule

// File: tb/tb_button_decoder.sv
// Self-checking bench for button_decoder: directed scenarios plus random button traffic
// compared cycle by cycle against a run-length reference model.
module tb_button_decoder;

    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst;
    logic sw_n;
    logic pressed;
    logic press_pulse;
    logic short_press;
    logic long_press;

    always #5 clk = ~clk;

    button_decoder #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_n(sw_n),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .short_press(short_press),
        .long_press(long_press)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: raw samples reach the decision logic two edges late; a level
    // change is accepted after D+1 consecutive edges seeing the opposite level.
    bit q_sync[$];
    bit m_pressed, m_flag, e_pp, e_sp, e_lp;
    int m_run, m_age;

    int n_press, n_short, n_long, n_hi;
    int t_press, t_short, t_long, t_fall;
    bit prev_p;
    int t0, t_rel;

    function automatic void model_reset();
        q_sync = '{1'b1, 1'b1};
        m_pressed = 1'b0;
        m_flag = 1'b0;
        m_run = 0;
        m_age = 0;
        e_pp = 1'b0;
        e_sp = 1'b0;
        e_lp = 1'b0;
    endfunction

    function automatic void model_edge(bit x);
        bit eff, old, flip;
        eff = q_sync.pop_front();
        q_sync.push_back(x);
        e_pp = 1'b0;
        e_sp = 1'b0;
        e_lp = 1'b0;
        old = m_pressed;
        flip = 1'b0;
        if ((!eff) != m_pressed) m_run++;
        else m_run = 0;
        if (m_run == D + 1) begin
            flip = 1'b1;
            m_run = 0;
        end
`ifdef BUTTON_DECODER_LONG_PRESS_EN
        if (old && m_age < L) begin
            m_age++;
            if (m_age == L && !flip && !m_flag) begin
                e_lp = 1'b1;
                m_flag = 1'b1;
            end
        end
`endif
        if (flip && !old) begin
            m_pressed = 1'b1;
            e_pp = 1'b1;
            m_age = 0;
        end else if (flip && old) begin
            m_pressed = 1'b0;
            e_sp = !m_flag;
            m_flag = 1'b0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_outputs();
        check("pressed", 32'(pressed), 32'(m_pressed));
        check("press_pulse", 32'(press_pulse), 32'(e_pp));
        check("short_press", 32'(short_press), 32'(e_sp));
        check("long_press", 32'(long_press), 32'(e_lp));
    endtask

    task automatic clear_stats();
        n_press = 0; n_short = 0; n_long = 0; n_hi = 0;
        t_press = -1000; t_short = -1000; t_long = -1000; t_fall = -1000;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(sw_n);
        #1;
        cyc++;
        compare_outputs();
        if (press_pulse === 1'b1) begin n_press++; t_press = cyc; end
        if (short_press === 1'b1) begin n_short++; t_short = cyc; end
        if (long_press === 1'b1) begin n_long++; t_long = cyc; end
        if (pressed === 1'b1) n_hi++;
        if (prev_p && pressed === 1'b0) t_fall = cyc;
        prev_p = (pressed === 1'b1);
    endtask

    task automatic hold(input bit v, input int n);
        sw_n = v;
        repeat (n) tick();
    endtask

    initial begin
        int seg_len;
        bit seg_v;
        rst = 1'b1;
        sw_n = 1'b1;
        prev_p = 1'b0;
        model_reset();
        clear_stats();
        repeat (3) tick();
        check("reset_pressed", 32'(pressed), 32'd0);
        check("reset_pulses", 32'({press_pulse, short_press, long_press}), 32'd0);
        rst = 1'b0;
        hold(1'b1, 5);

        // Clean long hold
        clear_stats();
        t0 = cyc + 1;
        hold(1'b0, 30);
        t_rel = cyc + 1;
        hold(1'b1, 15);
        check("clean_press_count", n_press, 1);
        check("clean_press_latency", t_press - t0, D + 2);
        check("clean_fall_latency", t_fall - t_rel, D + 2);
`ifdef BUTTON_DECODER_LONG_PRESS_EN
        check("clean_long_count", n_long, 1);
        check("clean_long_latency", t_long - t_press, L);
        check("clean_short_count", n_short, 0);
`else
        check("clean_long_count", n_long, 0);
        check("clean_short_count", n_short, 1);
        check("clean_short_latency", t_short - t_rel, D + 2);
`endif
        $display("scenario clean_hold: press=%0d long=%0d short=%0d", n_press, n_long, n_short);

        // Short press
        clear_stats();
        t0 = cyc + 1;
        hold(1'b0, 10);
        t_rel = cyc + 1;
        hold(1'b1, 12);
        check("short_press_count", n_press, 1);
        check("short_short_count", n_short, 1);
        check("short_short_latency", t_short - t_rel, D + 2);
        check("short_long_count", n_long, 0);
        $display("scenario short_press: press=%0d long=%0d short=%0d", n_press, n_long, n_short);

        // Bounce rejection
        clear_stats();
        repeat (5) begin
            hold(1'b0, 3);
            hold(1'b1, 1);
        end
        hold(1'b1, 10);
        check("bounce_pressed_cycles", n_hi, 0);
        check("bounce_press_count", n_press, 0);
        check("bounce_short_count", n_short, 0);
        check("bounce_long_count", n_long, 0);
        $display("scenario bounce: pressed_cycles=%0d press=%0d", n_hi, n_press);

        // Release glitch
        clear_stats();
        hold(1'b0, 8);
        hold(1'b1, 2);
        hold(1'b0, 6);
        check("glitch_pressed", 32'(pressed), 32'd1);
        check("glitch_short_count", n_short, 0);
        check("glitch_no_fall", t_fall, -1000);
        hold(1'b1, 12);
        $display("scenario release_glitch: press=%0d short=%0d", n_press, n_short);

        // Reset mid-hold
        clear_stats();
        t0 = cyc + 1;
        hold(1'b0, 19);
        check("rst_first_press_latency", t_press - t0, D + 2);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_pressed", 32'(pressed), 32'd0);
        check("rst_async_pulses", 32'({press_pulse, short_press, long_press}), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        clear_stats();
        t0 = cyc + 1;
        hold(1'b0, 30);
        check("rst_new_press_count", n_press, 1);
        check("rst_new_press_latency", t_press - t0, D + 2);
`ifdef BUTTON_DECODER_LONG_PRESS_EN
        check("rst_long_latency", t_long - t_press, L);
`else
        check("rst_long_count", n_long, 0);
`endif
        hold(1'b1, 12);
        $display("scenario reset_mid_hold: press=%0d long=%0d short=%0d", n_press, n_long, n_short);

        // Random traffic: short bursts model bounce, long ones real presses
        for (int i = 0; i < 150; i++) begin
            seg_v = 1'($urandom_range(0, 1));
            seg_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 35)) : int'($urandom_range(1, 6));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                model_reset();
                repeat ($urandom_range(1, 3)) tick();
                rst = 1'b0;
            end
            clear_stats();
            hold(seg_v, seg_len);
            $display("random seg %0d: sw_n=%0d len=%0d press=%0d short=%0d long=%0d",
                     i, seg_v, seg_len, n_press, n_short, n_long);
        end
        hold(1'b1, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_decoder.md
BUTTON_DECODER -- requirements
Module: button_decoder

Interface
REQ-001 The parameter DEBOUNCE_CYCLES SHALL default to 270000 and give the number of cycles an input change must stay stable before it is accepted (10 ms at 27 MHz).
REQ-002 The parameter LONG_CYCLES SHALL default to 27000000 and give the hold time in cycles that makes a press long (1 s at 27 MHz).
REQ-003 Port clk SHALL be an input, 1 bit wide: the single system clock, rising-edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port sw_n SHALL be an input, 1 bit wide: raw asynchronous push-button level, active-low (0 = pressed).
REQ-006 Port pressed SHALL be an output, 1 bit wide: debounced button level, 1 while held.
REQ-007 Port press_pulse SHALL be an output, 1 bit wide: one-cycle pulse on a debounced press edge.
REQ-008 Port short_press SHALL be an output, 1 bit wide: one-cycle pulse on a debounced release of a short press.
REQ-009 Port long_press SHALL be an output, 1 bit wide: one-cycle pulse when the hold time reaches LONG_CYCLES.

Function
REQ-010 sw_n SHALL pass through a two-flop synchronizer; its reset value is 1 (released). Only the synchronized bit sw_s is used downstream.
REQ-011 The FSM SHALL have four states. IDLE: released and stable. DEB_PRESS: press candidate. HELD: pressed and stable. DEB_REL: release candidate.
REQ-012 In IDLE, sw_s=0 SHALL cause a move to DEB_PRESS and clear the debounce counter.
REQ-013 In DEB_PRESS, the debounce counter SHALL increment each cycle sw_s=0. sw_s=1 SHALL return the FSM to IDLE with no output.
REQ-014 In DEB_PRESS, when the counter reaches DEBOUNCE_CYCLES-1 with sw_s=0, the FSM SHALL go to HELD, set pressed=1 and pulse press_pulse for exactly one cycle.
REQ-015 Press latency SHALL be DEBOUNCE_CYCLES+2 cycles from the first clock edge sampling sw_n=0 to press_pulse=1.
REQ-016 In HELD, sw_s=1 SHALL move the FSM to DEB_REL and clear the debounce counter.
REQ-017 DEB_REL SHALL mirror DEB_PRESS. sw_s=0 before the count completes SHALL return the FSM to HELD with pressed kept at 1 and no pulse.
REQ-018 When the DEB_REL count completes, the FSM SHALL go to IDLE, clear pressed, and pulse short_press for one cycle, subject to REQ-020.
REQ-019 The hold counter SHALL clear in the press_pulse cycle and increment every cycle while pressed=1, including in DEB_REL. It SHALL saturate at LONG_CYCLES and never wrap.
REQ-020 If the hold counter reaches LONG_CYCLES, the following SHALL apply:
  - long_press pulses for one cycle, exactly LONG_CYCLES cycles after press_pulse, while still pressed;
  - a long-press flag is set, which suppresses short_press on the subsequent release;
  - the flag clears when the FSM returns to IDLE.
REQ-021 press_pulse, short_press and long_press SHALL never assert in the same cycle, and each SHALL be at most one cycle wide.
REQ-022 Counter widths SHALL be $clog2(param+1). Counters use unsigned arithmetic.

Reset
REQ-023 While rst=1, regardless of clk, the design SHALL hold:
  - FSM in IDLE;
  - synchronizer flops at 1;
  - all counters and the long-press flag at 0;
  - pressed, press_pulse, short_press and long_press at 0.
REQ-024 Reset asserted mid-press SHALL abort the press with no pulse. After deassertion, a button still held SHALL be debounced afresh and produce a new press_pulse.

Configuration
REQ-025 When the macro BUTTON_DECODER_LONG_PRESS_EN is defined, REQ-019 and REQ-020 SHALL apply as written.
REQ-026 When BUTTON_DECODER_LONG_PRESS_EN is not defined, the following SHALL apply:
  - the hold counter and long-press flag are not built;
  - long_press is tied to 0;
  - every completed release pulses short_press;
  - LONG_CYCLES is ignored.

Verification (bench parameters DEBOUNCE_CYCLES=4, LONG_CYCLES=20; macro defined unless noted)
REQ-027 Clean press: sw_n 1->0 held 30 cycles, then 1. Required response:
  - press_pulse fires once, 6 cycles after the first low sample;
  - long_press fires 20 cycles after press_pulse;
  - pressed falls 6 cycles after release;
  - no short_press.
REQ-028 Short press: sw_n low for 10 cycles. Required response: one press_pulse, then one short_press 6 cycles after the release; long_press stays 0.
REQ-029 Bounce rejection: sw_n low 3 cycles, high 1 cycle, repeated 5 times, then high. Required response: pressed, press_pulse, short_press and long_press all stay 0.
REQ-030 Release glitch: press held stable, then sw_n high for 2 cycles and low again. Required response: pressed stays 1 and no short_press fires.
REQ-031 Reset mid-hold: rst pulsed 3 cycles while sw_n=0, 12 cycles after press_pulse. Required response:
  - all outputs 0 during reset;
  - a new press_pulse 6 cycles after the first post-reset edge;
  - long_press 20 cycles after that new press_pulse.
REQ-032 Macro undefined: rerun the REQ-027 stimulus. Required response: long_press stays 0 and one short_press fires 6 cycles after the release.
